// File: rtl/fc_ibuf_ctrl.sv
// fc_ibuf_ctrl: sequencer for the fully-connected input buffer of one FC layer.
//
// Counts element writes from the previous layer into the buffer FIFOs. It then
// runs the bit-serial read-out. For each bit-plane it sweeps every buffer address
// onto the crossbar input bus, launches one crossbar compute, waits for it, and
// shifts the buffer right by one bit.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_start           begin one layer pass (only looked at in IDLE)
//   i_valid, o_ready  write handshake from the previous layer (FILL only)
//   o_we, o_se        fc_ibuf write / shift enables
//   o_ibuf_addr       fc_ibuf read address
//   o_load_valid,
//   i_load_ready      per-address handshake toward the crossbar input register
//   o_compute_start,
//   i_compute_done    crossbar compute launch pulse / completion
//   o_bit_idx         current bit-plane (shift weight for the accumulator)
//   o_busy, o_done    pass in progress / one-cycle end-of-pass pulse
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for i_start; counters hold their last values
// FILL    | accepting FIFO_LENGTH writes from the previous layer
// LOAD    | presenting addresses 0..NUM_ADDR-1 to the crossbar input
// COMPUTE | crossbar compute launched, waiting for i_compute_done
// SHIFT   | one-cycle buffer shift, advance to the next bit-plane
// DONE    | one-cycle end-of-pass pulse

module fc_ibuf_ctrl #(
  parameter int DATA_SIZE   = 8,
  parameter int FIFO_LENGTH = 4,
  parameter int NUM_ADDR    = 8,
  parameter int ADDR_W      = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1,
  parameter int BIT_W       = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_we,
  output logic              o_se,
  output logic [ADDR_W-1:0] o_ibuf_addr,
  output logic              o_load_valid,
  input  logic              i_load_ready,
  output logic              o_compute_start,
  input  logic              i_compute_done,
  output logic [BIT_W-1:0]  o_bit_idx,
  output logic              o_busy,
  output logic              o_done
);

  localparam int FILL_W = $clog2(FIFO_LENGTH + 1);

  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FIFO_LENGTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_ADDR - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_LOAD,
    S_COMPUTE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [FILL_W-1:0]   fill_cnt, fill_cnt_nxt;
  logic [ADDR_W-1:0]   addr_cnt, addr_cnt_nxt;
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_nxt;
  // Set only on the LOAD->COMPUTE transition so the compute launch is a
  // registered single-cycle pulse even if done takes many cycles.
  logic                compute_first, compute_first_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      fill_cnt      <= '0;
      addr_cnt      <= '0;
      bit_cnt       <= '0;
      compute_first <= 1'b0;
    end else begin
      state         <= state_nxt;
      fill_cnt      <= fill_cnt_nxt;
      addr_cnt      <= addr_cnt_nxt;
      bit_cnt       <= bit_cnt_nxt;
      compute_first <= compute_first_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    fill_cnt_nxt      = fill_cnt;
    addr_cnt_nxt      = addr_cnt;
    bit_cnt_nxt       = bit_cnt;
    compute_first_nxt = 1'b0;
    o_ready           = 1'b0;
    o_we              = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_nxt    = S_FILL;
          fill_cnt_nxt = '0;
          addr_cnt_nxt = '0;
          bit_cnt_nxt  = '0;
        end
      end
      S_FILL: begin
        o_ready = 1'b1;
        o_we    = i_valid;
        if (i_valid) begin
          fill_cnt_nxt = fill_cnt + FILL_W'(1);
          if (fill_cnt == FILL_LAST) state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (i_load_ready) begin
          if (addr_cnt == ADDR_LAST) begin
            addr_cnt_nxt      = '0;
            state_nxt         = S_COMPUTE;
            compute_first_nxt = 1'b1;
          end else begin
            addr_cnt_nxt = addr_cnt + ADDR_W'(1);
          end
        end
      end
      S_COMPUTE: begin
        if (i_compute_done) state_nxt = (bit_cnt == BIT_LAST) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        bit_cnt_nxt = bit_cnt + BIT_W'(1);
        state_nxt   = S_LOAD;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // addr_cnt is zero outside LOAD, so the address bus is quiet between sweeps.
  assign o_ibuf_addr     = addr_cnt;
  assign o_bit_idx       = bit_cnt;
  assign o_load_valid    = (state == S_LOAD);
  assign o_compute_start = (state == S_COMPUTE) && compute_first;
  assign o_se            = (state == S_SHIFT);
  assign o_busy          = (state != S_IDLE);
  assign o_done          = (state == S_DONE);

endmodule

// File: tb/tb_fc_ibuf_ctrl.sv
// Testbench for fc_ibuf_ctrl. Two instances are exercised side by side:
// instance 0 uses FIFO_LENGTH=4, NUM_ADDR=3, DATA_SIZE=2, and instance 1 uses
// FIFO_LENGTH=4, NUM_ADDR=1, DATA_SIZE=1. A procedural pass model, written as
// nested loops over bit-planes and addresses, predicts every output each cycle.
// Literal cycle-by-cycle expectations for the directed scenarios pin that model.
module tb_fc_ibuf_ctrl;

  localparam int FL_A = 4, NA_A = 3, DS_A = 2;
  localparam int FL_B = 4, NA_B = 1, DS_B = 1;
  localparam int AW_A = (NA_A > 1) ? $clog2(NA_A) : 1;
  localparam int BW_A = (DS_A > 1) ? $clog2(DS_A) : 1;
  localparam int AW_B = (NA_B > 1) ? $clog2(NA_B) : 1;
  localparam int BW_B = (DS_B > 1) ? $clog2(DS_B) : 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st[2], vl[2], lr[2], cd[2];

  logic            a_ready, a_we, a_se, a_lv, a_cs, a_busy, a_done;
  logic [AW_A-1:0] a_addr;
  logic [BW_A-1:0] a_bit;
  logic            b_ready, b_we, b_se, b_lv, b_cs, b_busy, b_done;
  logic [AW_B-1:0] b_addr;
  logic [BW_B-1:0] b_bit;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fc_ibuf_ctrl #(.DATA_SIZE(DS_A), .FIFO_LENGTH(FL_A), .NUM_ADDR(NA_A)) dut_a (
    .clk(clk), .rst(rst), .i_start(st[0]), .i_valid(vl[0]), .o_ready(a_ready),
    .o_we(a_we), .o_se(a_se), .o_ibuf_addr(a_addr), .o_load_valid(a_lv),
    .i_load_ready(lr[0]), .o_compute_start(a_cs), .i_compute_done(cd[0]),
    .o_bit_idx(a_bit), .o_busy(a_busy), .o_done(a_done));

  fc_ibuf_ctrl #(.DATA_SIZE(DS_B), .FIFO_LENGTH(FL_B), .NUM_ADDR(NA_B)) dut_b (
    .clk(clk), .rst(rst), .i_start(st[1]), .i_valid(vl[1]), .o_ready(b_ready),
    .o_we(b_we), .o_se(b_se), .o_ibuf_addr(b_addr), .o_load_valid(b_lv),
    .i_load_ready(lr[1]), .o_compute_start(b_cs), .i_compute_done(cd[1]),
    .o_bit_idx(b_bit), .o_busy(b_busy), .o_done(b_done));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_assert++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic e_ready[2], e_we[2], e_se[2], e_lv[2], e_cs[2], e_busy[2], e_done[2];
  int   e_addr[2], e_bit[2];
  int   last_bit[2];

  task automatic set_exp(input int k, input logic rdy, input logic we, input logic se,
                         input int addr, input logic lv, input logic cs, input int bitv,
                         input logic busy, input logic done);
    e_ready[k] = rdy; e_we[k] = we; e_se[k] = se; e_addr[k] = addr; e_lv[k] = lv;
    e_cs[k] = cs; e_bit[k] = bitv; e_busy[k] = busy; e_done[k] = done;
  endtask

  // Advance the model one cycle; a reset abandons the pass and zeroes everything.
  task automatic tick(input int k, output bit r);
    @(negedge clk);
    r = rst;
    if (r) begin
      last_bit[k] = 0;
      set_exp(k, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic model(input int k, input int fl, input int na, input int ds);
    bit r;
    int f;
    bit first;
    do begin
      tick(k, r);
      if (!r) set_exp(k, 0, 0, 0, 0, 0, 0, last_bit[k], 0, 0);
    end while (r || !st[k]);
    last_bit[k] = 0;
    f = 0;
    while (f < fl) begin
      tick(k, r);
      if (r) return;
      set_exp(k, 1, vl[k], 0, 0, 0, 0, 0, 1, 0);
      if (vl[k]) f++;
    end
    for (int b = 0; b < ds; b++) begin
      for (int a = 0; a < na; ) begin
        tick(k, r);
        if (r) return;
        set_exp(k, 0, 0, 0, a, 1, 0, b, 1, 0);
        if (lr[k]) a++;
      end
      first = 1'b1;
      do begin
        tick(k, r);
        if (r) return;
        set_exp(k, 0, 0, 0, 0, 0, first, b, 1, 0);
        first = 1'b0;
      end while (!cd[k]);
      if (b != ds - 1) begin
        tick(k, r);
        if (r) return;
        set_exp(k, 0, 0, 1, 0, 0, 0, b, 1, 0);
      end
    end
    tick(k, r);
    if (r) return;
    set_exp(k, 0, 0, 0, 0, 0, 0, ds - 1, 1, 1);
    last_bit[k] = ds - 1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      last_bit[k] = 0;
      set_exp(k, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
  end
  initial forever model(0, FL_A, NA_A, DS_A);
  initial forever model(1, FL_B, NA_B, DS_B);

  task automatic cmp(input int k, input logic rdy, input logic we, input logic se,
                     input int addr, input logic lv, input logic cs, input int bitv,
                     input logic busy, input logic done);
    chk($sformatf("dut%0d o_ready", k), rdy, e_ready[k]);
    chk($sformatf("dut%0d o_we", k), we, e_we[k]);
    chk($sformatf("dut%0d o_se", k), se, e_se[k]);
    chk($sformatf("dut%0d o_ibuf_addr", k), addr, e_addr[k]);
    chk($sformatf("dut%0d o_load_valid", k), lv, e_lv[k]);
    chk($sformatf("dut%0d o_compute_start", k), cs, e_cs[k]);
    chk($sformatf("dut%0d o_bit_idx", k), bitv, e_bit[k]);
    chk($sformatf("dut%0d o_busy", k), busy, e_busy[k]);
    chk($sformatf("dut%0d o_done", k), done, e_done[k]);
    chk($sformatf("dut%0d we_se_exclusive", k), we & se, 1'b0);
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    cmp(0, a_ready, a_we, a_se, int'(a_addr), a_lv, a_cs, int'(a_bit), a_busy, a_done);
    cmp(1, b_ready, b_we, b_se, int'(b_addr), b_lv, b_cs, int'(b_bit), b_busy, b_done);
  end

  // ---------------- directed stimulus with history capture ----------------
  logic h_we[2][33], h_lv[2][33], h_cs[2][33], h_se[2][33], h_done[2][33], h_busy[2][33];
  int   h_addr[2][33], h_bit[2][33];

  task automatic drive_all(input logic v);
    for (int k = 0; k < 2; k++) begin
      vl[k] = v; lr[k] = v; cd[k] = v;
    end
  endtask

  // Drives cycle 0 (i_start sampled at its closing edge); returns at start of cycle 1.
  task automatic start_pass(input logic s0, input logic s1);
    st[0] = s0; st[1] = s1;
    @(posedge clk); #1;
    st[0] = 1'b0; st[1] = 1'b0;
  endtask

  // mode 0: handshakes high; 1: stalls / slow compute / ignored inputs; 2: mid-pass reset
  task automatic run_cycles(input int n, input int mode);
    for (int c = 1; c <= n; c++) begin
      if (mode == 0) begin
        drive_all(1'b1);
      end else if (mode == 1) begin
        for (int k = 0; k < 2; k++) begin
          vl[k] = !(c >= 2 && c <= 4);
          lr[k] = !(c == 9 || c == 10);
          cd[k] = (c >= 18);
        end
        st[0] = (c == 21);
      end else begin
        drive_all(1'b1);
        rst = (c == 11 || c == 12);
      end
      if (mode == 2 && c == 11) begin
        #1;
        chk("async reset o_busy", a_busy, 1'b0);
        chk("async reset o_load_valid", a_lv, 1'b0);
        chk("async reset o_bit_idx", a_bit, 0);
      end
      @(negedge clk);
      h_we[0][c] = a_we; h_lv[0][c] = a_lv; h_cs[0][c] = a_cs; h_se[0][c] = a_se;
      h_done[0][c] = a_done; h_busy[0][c] = a_busy; h_addr[0][c] = int'(a_addr); h_bit[0][c] = int'(a_bit);
      h_we[1][c] = b_we; h_lv[1][c] = b_lv; h_cs[1][c] = b_cs; h_se[1][c] = b_se;
      h_done[1][c] = b_done; h_busy[1][c] = b_busy; h_addr[1][c] = int'(b_addr); h_bit[1][c] = int'(b_bit);
      @(posedge clk); #1;
      st[0] = 1'b0;
    end
  endtask

  task automatic check_nominal(input string tag);
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("%s a we c%0d", tag, c), h_we[0][c], (c >= 1 && c <= 4));
      chk($sformatf("%s a lv c%0d", tag, c), h_lv[0][c], ((c >= 5 && c <= 7) || (c >= 10 && c <= 12)));
      if (c >= 5 && c <= 7)   chk($sformatf("%s a addr c%0d", tag, c), h_addr[0][c], c - 5);
      if (c >= 10 && c <= 12) chk($sformatf("%s a addr c%0d", tag, c), h_addr[0][c], c - 10);
      chk($sformatf("%s a cs c%0d", tag, c), h_cs[0][c], (c == 8 || c == 13));
      chk($sformatf("%s a se c%0d", tag, c), h_se[0][c], (c == 9));
      chk($sformatf("%s a done c%0d", tag, c), h_done[0][c], (c == 14));
      chk($sformatf("%s a bit c%0d", tag, c), h_bit[0][c], (c >= 10) ? 1 : 0);
      chk($sformatf("%s a busy c%0d", tag, c), h_busy[0][c], (c <= 14));
      chk($sformatf("%s b lv c%0d", tag, c), h_lv[1][c], (c == 5));
      chk($sformatf("%s b cs c%0d", tag, c), h_cs[1][c], (c == 6));
      chk($sformatf("%s b done c%0d", tag, c), h_done[1][c], (c == 7));
      chk($sformatf("%s b se c%0d", tag, c), h_se[1][c], 1'b0);
      chk($sformatf("%s b busy c%0d", tag, c), h_busy[1][c], (c <= 7));
    end
  endtask

  initial begin
    int cnt_we, cnt_hold, cnt_cs, cnt_se, cnt_done, rnd_done;
    for (int k = 0; k < 2; k++) begin
      st[k] = 1'b0; vl[k] = 1'b0; lr[k] = 1'b0; cd[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset o_busy", a_busy, 1'b0);
    chk("reset o_ready", a_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Nominal pass on both instances, starting right after reset release.
    drive_all(1'b1);
    start_pass(1'b1, 1'b1);
    run_cycles(16, 0);
    check_nominal("nominal");

    // Stalls, slow compute, i_start and i_valid ignored outside IDLE/FILL.
    drive_all(1'b1);
    start_pass(1'b1, 1'b1);
    run_cycles(26, 1);
    cnt_we = 0; cnt_hold = 0; cnt_cs = 0; cnt_se = 0; cnt_done = 0;
    for (int c = 1; c <= 26; c++) begin
      cnt_we   += int'(h_we[0][c]);
      cnt_hold += int'(h_lv[0][c] && h_addr[0][c] == 1 && h_bit[0][c] == 0);
      cnt_cs   += int'(h_cs[0][c]);
      cnt_se   += int'(h_se[0][c]);
      cnt_done += int'(h_done[0][c]);
    end
    chk("stall we pulses", cnt_we, 4);
    chk("stall addr1 hold cycles", cnt_hold, 3);
    chk("stall addr2 reached c12", h_lv[0][12] && h_addr[0][12] == 2, 1'b1);
    chk("stall cs pulses", cnt_cs, 2);
    chk("slow compute cs c13", h_cs[0][13], 1'b1);
    chk("slow compute se c19", h_se[0][19], 1'b1);
    chk("stall se pulses", cnt_se, 1);
    chk("ignored start done c24", h_done[0][24], 1'b1);
    chk("ignored start done pulses", cnt_done, 1);
    chk("ignored start idle c25", h_busy[0][25], 1'b0);
    chk("single corner done c19", h_done[1][19], 1'b1);

    // Mid-pass reset during the second LOAD, then a replay.
    drive_all(1'b1);
    start_pass(1'b1, 1'b0);
    run_cycles(14, 2);
    cnt_done = 0;
    for (int c = 1; c <= 14; c++) cnt_done += int'(h_done[0][c]);
    chk("mid reset no done", cnt_done, 0);
    chk("mid reset idle c13", h_busy[0][13], 1'b0);
    drive_all(1'b1);
    start_pass(1'b1, 1'b1);
    run_cycles(16, 0);
    check_nominal("replay");

    // Randomized traffic, including occasional resets.
    rnd_done = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        vl[k] = ($urandom_range(0, 3) != 0);
        lr[k] = ($urandom_range(0, 3) != 0);
        cd[k] = ($urandom_range(0, 3) == 0);
        st[k] = ($urandom_range(0, 5) == 0);
      end
      rst = ($urandom_range(0, 399) == 0);
      @(negedge clk);
      rnd_done += int'(a_done);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    chk("random passes completed", rnd_done > 10, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
